// File: rtl/obstacle_scheduler_if.sv
// Renderer-side bus of the obstacle scheduler: raster/frame controls in, selected sprite out.
interface obstacle_scheduler_if;
    localparam int unsigned HC_W    = 11;
    localparam int unsigned VC_W    = 10;
    localparam int unsigned SPEED_W = 4;
    localparam int unsigned SHAPE_W = 2;
    localparam int unsigned COUNT_W = 8;

    logic [HC_W-1:0]    hcount_in;
    logic [VC_W-1:0]    vcount_in;
    logic               new_frame_in;
    logic               run_in;
    logic [SPEED_W-1:0] speed_in;
    logic [HC_W-1:0]    x_out;
    logic [VC_W-1:0]    y_out;
    logic [SHAPE_W-1:0] shape_out;
    logic               active_out;
    logic               busy_out;
    logic [COUNT_W-1:0] spawn_count_out;

    modport master (
        output hcount_in, vcount_in, new_frame_in, run_in, speed_in,
        input  x_out, y_out, shape_out, active_out, busy_out, spawn_count_out
    );

    modport slave (
        input  hcount_in, vcount_in, new_frame_in, run_in, speed_in,
        output x_out, y_out, shape_out, active_out, busy_out, spawn_count_out
    );
endinterface

// File: rtl/obstacle_scheduler.sv
// Shares one masked sprite renderer among NUM_SLOTS obstacles: per-frame table update
// in vertical blank, per-pixel x/shape selection during active video.
module obstacle_scheduler #(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned SPRITE_W  = 128,
    parameter int unsigned SCREEN_W  = 1280,
    parameter int unsigned GROUND_Y  = 592,
    parameter int unsigned MIN_GAP   = 256
) (
    input logic                 pixel_clk_in,
    input logic                 rst_n_in,
    obstacle_scheduler_if.slave bus
);
    localparam int unsigned IDX_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int unsigned X_W    = 11;
    localparam int unsigned CMP_W  = 12;
    localparam int unsigned LFSR_W = 16;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MOVE  = 2'd1;
    localparam logic [1:0] SPAWN = 2'd2;
    localparam logic [1:0] PARK  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [3:0]           spd_q, spd_d;
    logic [NUM_SLOTS-1:0] valid_q, valid_d;
    logic [X_W-1:0]       x_q [NUM_SLOTS];
    logic [X_W-1:0]       x_d [NUM_SLOTS];
    logic [1:0]           shape_q [NUM_SLOTS];
    logic [1:0]           shape_d [NUM_SLOTS];
    logic [X_W-1:0]       dist_q, dist_d;
    logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
    logic [X_W-1:0]       sel_x_q, sel_x_d;
    logic [1:0]           sel_shape_q, sel_shape_d;
    logic                 active_q, active_d;
    logic                 busy_q, busy_d;
    logic [7:0]           count_q, count_d;

    logic                 hit_c;
    logic [IDX_W-1:0]     hit_idx_c;
    logic                 free_c;
    logic [IDX_W-1:0]     free_idx_c;
    logic [CMP_W-1:0]     dist_sum_c;
    logic [CMP_W-1:0]     spawn_thr_c;
    logic                 unused_vcount;

    assign unused_vcount = ^bus.vcount_in;

    // Lowest-index slot covering the current pixel, and lowest free slot.
    always_comb begin
        hit_c      = 1'b0;
        hit_idx_c  = '0;
        free_c     = 1'b0;
        free_idx_c = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (valid_q[i] && ({1'b0, bus.hcount_in} >= {1'b0, x_q[i]}) &&
                ({1'b0, bus.hcount_in} < ({1'b0, x_q[i]} + CMP_W'(SPRITE_W)))) begin
                hit_c     = 1'b1;
                hit_idx_c = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                free_c     = 1'b1;
                free_idx_c = IDX_W'(i);
            end
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        spd_d       = spd_q;
        valid_d     = valid_q;
        x_d         = x_q;
        shape_d     = shape_q;
        dist_d      = dist_q;
        lfsr_d      = lfsr_q;
        sel_x_d     = sel_x_q;
        sel_shape_d = sel_shape_q;
        count_d     = count_q;
        dist_sum_c  = CMP_W'(dist_q) + CMP_W'(spd_q);
        spawn_thr_c = CMP_W'(MIN_GAP) + CMP_W'(lfsr_q[7:0]);

        case (state_q)
            IDLE: begin
                if (hit_c) begin
                    sel_x_d     = x_q[hit_idx_c];
                    sel_shape_d = shape_q[hit_idx_c];
                end
                if (bus.new_frame_in && bus.run_in) begin
                    spd_d   = bus.speed_in;
                    idx_d   = '0;
                    state_d = MOVE;
                end
            end
            MOVE: begin
                if (valid_q[idx_q]) begin
                    if (x_q[idx_q] < X_W'(spd_q)) valid_d[idx_q] = 1'b0;
                    else x_d[idx_q] = x_q[idx_q] - X_W'(spd_q);
                end
                if (idx_q == '0) begin
                    dist_d = (dist_sum_c > CMP_W'(2047)) ? X_W'(2047) : dist_sum_c[X_W-1:0];
                end
                if (idx_q == IDX_W'(NUM_SLOTS - 1)) state_d = SPAWN;
                else idx_d = idx_q + IDX_W'(1);
            end
            SPAWN: begin
                if ((CMP_W'(dist_q) >= spawn_thr_c) && free_c) begin
                    valid_d[free_idx_c] = 1'b1;
                    x_d[free_idx_c]     = X_W'(SCREEN_W);
                    shape_d[free_idx_c] = lfsr_q[1:0];
                    dist_d              = '0;
                    count_d             = count_q + 8'd1;
                end
                lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
                state_d = PARK;
            end
            default: begin
                sel_x_d     = X_W'(2047);
                sel_shape_d = 2'd0;
                state_d     = IDLE;
            end
        endcase

        busy_d   = (state_d != IDLE);
        active_d = |valid_q;
    end

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            spd_q       <= '0;
            valid_q     <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i]     <= '0;
                shape_q[i] <= '0;
            end
            dist_q      <= X_W'(2047);
            lfsr_q      <= 16'hACE1;
            sel_x_q     <= X_W'(2047);
            sel_shape_q <= '0;
            active_q    <= 1'b0;
            busy_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            spd_q       <= spd_d;
            valid_q     <= valid_d;
            x_q         <= x_d;
            shape_q     <= shape_d;
            dist_q      <= dist_d;
            lfsr_q      <= lfsr_d;
            sel_x_q     <= sel_x_d;
            sel_shape_q <= sel_shape_d;
            active_q    <= active_d;
            busy_q      <= busy_d;
            count_q     <= count_d;
        end
    end

    assign bus.x_out           = sel_x_q;
    assign bus.y_out           = 10'(GROUND_Y);
    assign bus.shape_out       = sel_shape_q;
    assign bus.active_out      = active_q;
    assign bus.busy_out        = busy_q;
    assign bus.spawn_count_out = count_q;
endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench for obstacle_scheduler: behavioural slot-table model feeding scoreboards.
module tb_obstacle_scheduler;
    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned SPRITE_W  = 128;
    localparam int unsigned SCREEN_W  = 1280;
    localparam int unsigned GROUND_Y  = 592;
    localparam int unsigned MIN_GAP   = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    obstacle_scheduler_if bus ();

    obstacle_scheduler #(
        .NUM_SLOTS(NUM_SLOTS), .SPRITE_W(SPRITE_W), .SCREEN_W(SCREEN_W),
        .GROUND_Y(GROUND_Y), .MIN_GAP(MIN_GAP)
    ) dut (
        .pixel_clk_in(clk),
        .rst_n_in    (rst_n),
        .bus         (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the slot table
    bit          m_valid [NUM_SLOTS];
    int          m_x     [NUM_SLOTS];
    int          m_shape [NUM_SLOTS];
    int          m_dist;
    logic [15:0] m_lfsr;
    int          m_count;
    int          m_sel_x;
    int          m_sel_shape;
    int          n_full_seen;
    int          n_retire_seen;

    typedef struct {
        int count;
        bit active;
    } frame_exp_t;

    logic [12:0] sel_q   [$];
    frame_exp_t  frame_q [$];

    function automatic void model_reset();
        for (int i = 0; i < NUM_SLOTS; i++) begin
            m_valid[i] = 1'b0;
            m_x[i]     = 0;
            m_shape[i] = 0;
        end
        m_dist      = 2047;
        m_lfsr      = 16'hACE1;
        m_count     = 0;
        m_sel_x     = 2047;
        m_sel_shape = 0;
    endfunction

    function automatic bit model_active();
        bit a = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) a = a | m_valid[i];
        return a;
    endfunction

    function automatic void model_frame(input int spd);
        int free_slot = -1;
        int thr;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (m_valid[i]) begin
                if (m_x[i] < spd) begin
                    m_valid[i] = 1'b0;
                    n_retire_seen++;
                end else begin
                    m_x[i] = m_x[i] - spd;
                end
            end
        end
        m_dist = (m_dist + spd > 2047) ? 2047 : m_dist + spd;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) if (!m_valid[i]) free_slot = i;
        thr = MIN_GAP + int'(m_lfsr[7:0]);
        if (m_dist >= thr) begin
            if (free_slot >= 0) begin
                m_valid[free_slot] = 1'b1;
                m_x[free_slot]     = SCREEN_W;
                m_shape[free_slot] = int'(m_lfsr[1:0]);
                m_dist             = 0;
                m_count            = (m_count + 1) % 256;
            end else begin
                n_full_seen++;
            end
        end
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        m_sel_x     = 2047;
        m_sel_shape = 0;
    endfunction

    function automatic logic [12:0] model_pixel(input int h);
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (m_valid[i] && h >= m_x[i] && h < m_x[i] + SPRITE_W) begin
                m_sel_x     = m_x[i];
                m_sel_shape = m_shape[i];
                break;
            end
        end
        return {11'(m_sel_x), 2'(m_sel_shape)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.hcount_in = 11'd0; bus.vcount_in = 10'd0;
        bus.new_frame_in = 1'b0; bus.run_in = 1'b0; bus.speed_in = 4'd0;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.x_out !== 11'h7FF || bus.shape_out !== 2'd0 || bus.y_out !== 10'(GROUND_Y)) begin
            n_fail++;
            $display("FAIL reset_sel: x=%h shape=%0d y=%0d, want x=7ff shape=0 y=%0d",
                     bus.x_out, bus.shape_out, bus.y_out, GROUND_Y);
        end
        n_checks++;
        if (bus.active_out !== 1'b0 || bus.busy_out !== 1'b0 || bus.spawn_count_out !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_status: active=%b busy=%b count=%0d, want 0 0 0",
                     bus.active_out, bus.busy_out, bus.spawn_count_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drive an hcount sweep; each pixel's expected selection is checked one cycle later.
    task automatic test_sweep(input int h0, input int h1);
        logic [12:0] exp_sel;
        logic [12:0] got;
        for (int h = h0; h <= h1 + 1; h++) begin
            @(negedge clk);
            if (sel_q.size() != 0) begin
                exp_sel = sel_q.pop_front();
                got = {bus.x_out, bus.shape_out};
                n_checks++;
                if (got !== exp_sel) begin
                    n_fail++;
                    $display("FAIL sweep_sel h=%0d: x=%0d shape=%0d, want x=%0d shape=%0d",
                             h - 1, got[12:2], got[1:0], exp_sel[12:2], exp_sel[1:0]);
                end
            end
            if (h <= h1) begin
                bus.hcount_in = 11'(h);
                bus.vcount_in = 10'($urandom_range(0, 1023));
                sel_q.push_back(model_pixel(h));
            end else begin
                bus.hcount_in = 11'd2047;
            end
        end
    endtask

    task automatic test_frame(input int spd, input bit dup);
        frame_exp_t e;
        int busy_len = 0;
        @(negedge clk);
        bus.hcount_in    = 11'd2047;
        bus.run_in       = 1'b1;
        bus.speed_in     = 4'(spd);
        bus.new_frame_in = 1'b1;
        model_frame(spd);
        e.count  = m_count;
        e.active = model_active();
        frame_q.push_back(e);
        @(negedge clk);
        bus.new_frame_in = 1'b0;
        bus.speed_in     = 4'($urandom_range(0, 15));
        while (bus.busy_out === 1'b1 && busy_len < 20) begin
            busy_len++;
            bus.new_frame_in = dup && (busy_len == 2 || busy_len == 6);
            @(negedge clk);
        end
        bus.new_frame_in = 1'b0;
        e = frame_q.pop_front();
        n_checks++;
        if (busy_len != NUM_SLOTS + 2) begin
            n_fail++;
            $display("FAIL busy_len spd=%0d: %0d cycles, want %0d", spd, busy_len, NUM_SLOTS + 2);
        end
        n_checks++;
        if (bus.spawn_count_out !== 8'(e.count)) begin
            n_fail++;
            $display("FAIL spawn_count: %0d, want %0d", bus.spawn_count_out, e.count);
        end
        n_checks++;
        if (bus.active_out !== e.active) begin
            n_fail++;
            $display("FAIL active: %b, want %b", bus.active_out, e.active);
        end
        n_checks++;
        if (bus.x_out !== 11'h7FF || bus.shape_out !== 2'd0) begin
            n_fail++;
            $display("FAIL park_sel: x=%h shape=%0d, want 7ff 0", bus.x_out, bus.shape_out);
        end
    endtask

    task automatic test_freeze();
        bit busy_seen = 1'b0;
        @(negedge clk);
        bus.run_in       = 1'b0;
        bus.speed_in     = 4'd15;
        bus.new_frame_in = 1'b1;
        @(negedge clk);
        bus.new_frame_in = 1'b0;
        repeat (8) begin
            busy_seen = busy_seen | (bus.busy_out !== 1'b0);
            @(negedge clk);
        end
        bus.run_in = 1'b1;
        n_checks++;
        if (busy_seen || bus.spawn_count_out !== 8'(m_count) || bus.active_out !== model_active()) begin
            n_fail++;
            $display("FAIL freeze: busy_seen=%b count=%0d active=%b, want 0 %0d %b",
                     busy_seen, bus.spawn_count_out, bus.active_out, m_count, model_active());
        end
    endtask

    task automatic test_reset_mid_move();
        @(negedge clk);
        bus.run_in = 1'b1; bus.speed_in = 4'd9; bus.new_frame_in = 1'b1;
        @(negedge clk);
        bus.new_frame_in = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy_out !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: busy=%b, want 1", bus.busy_out);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.busy_out !== 1'b0 || bus.active_out !== 1'b0 || bus.spawn_count_out !== 8'd0 ||
            bus.x_out !== 11'h7FF || bus.shape_out !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b active=%b count=%0d x=%h shape=%0d, want 0 0 0 7ff 0",
                     bus.busy_out, bus.active_out, bus.spawn_count_out, bus.x_out, bus.shape_out);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_frame(4, 1'b0);
        test_sweep(1270, 1420);
    endtask

    task automatic test_long_run();
        for (int f = 0; f < 600; f++) begin
            test_frame($urandom_range(0, 15), (f % 37) == 0);
            if (f % 97 == 50) test_freeze();
            if (f % 50 == 49) test_sweep(0, 1450);
        end
        $display("info: long run saw %0d retires and %0d full-table suppressions",
                 n_retire_seen, n_full_seen);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_full_seen   = 0;
        n_retire_seen = 0;
        test_reset();
        test_sweep(0, 1450);
        test_frame(4, 1'b0);
        test_sweep(1270, 1420);
        test_frame(4, 1'b0);
        test_sweep(1270, 1420);
        test_freeze();
        test_frame(4, 1'b1);
        test_sweep(1200, 1420);
        test_long_run();
        test_reset_mid_move();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
